// File: rtl/vga_clock_pkg.sv
// Shared definitions for the VGA clock timekeeping core:
// field limits and widths, button indices, alarm record, wrap helpers.
package vga_clock_pkg;

    localparam int HOURS_MAX = 23;
    localparam int MINS_MAX  = 59;
    localparam int SECS_MAX  = 59;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int RING_W = 8;

    localparam int BTN_HOUR = 0;
    localparam int BTN_MIN  = 1;
    localparam int BTN_SEC  = 2;
    localparam int BTN_AL   = 3;
    localparam int BTN_TOG  = 4;
    localparam int NUM_BTNS = 5;

    typedef struct packed {
        logic              enable;
        logic [HOUR_W-1:0] hours;
        logic [MIN_W-1:0]  minutes;
    } alarm_t;

    function automatic logic [HOUR_W-1:0] hour_inc(
        input logic [HOUR_W-1:0] h
    );
        return (h == HOUR_W'(HOURS_MAX)) ? '0 : h + HOUR_W'(1);
    endfunction

    // Minutes and seconds share a width, so one helper serves both.
    function automatic logic [MIN_W-1:0] ms_inc(
        input logic [MIN_W-1:0] v,
        input int               max_v
    );
        return (v == MIN_W'(max_v)) ? '0 : v + MIN_W'(1);
    endfunction

endpackage

// File: rtl/clock_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, level debouncer, rising-edge pulse.
// Ports: clk, rst (async high), btn (raw), level (debounced), press (1-cycle).
module clock_btn_debounce #(
    parameter int DEBOUNCE_CYC = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;

    logic          sync_a;
    logic          sync_b;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a  <= 1'b0;
            sync_b  <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_a  <= btn;
            sync_b  <= sync_a;
            level_d <= level;
            press   <= level & ~level_d;
            // cnt holds how many consecutive samples disagreed so far
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                level <= sync_b;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_clock_timekeeper.sv
// Timekeeping and multi-alarm core: hh:mm:ss counter, button edits,
// alarms with ring timeout and square-wave buzzer.
// Inputs: video_clk, reset (async high), five raw buttons, al_sel.
// Outputs: hours/minutes/seconds, sec_tick, selected alarm fields,
// al_enabled, ringing, buzzer_out (all registered).
module vga_clock_timekeeper
    import vga_clock_pkg::*;
#(
    parameter int CLK_HZ        = 25_000_000,
    parameter int NUM_ALARMS    = 2,
    parameter int DEBOUNCE_CYC  = 250_000,
    parameter int BUZZ_HALF_CYC = 12_500,
    parameter int RING_SEC      = 60,
    parameter int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  video_clk,
    input  logic                  reset,
    input  logic                  hour_in,
    input  logic                  min_in,
    input  logic                  sec_in,
    input  logic                  al_in,
    input  logic                  al_on_off_toggle_in,
    input  logic [AW-1:0]         al_sel,
    output logic [HOUR_W-1:0]     hours,
    output logic [MIN_W-1:0]      minutes,
    output logic [MIN_W-1:0]      seconds,
    output logic                  sec_tick,
    output logic [HOUR_W-1:0]     al_hours,
    output logic [MIN_W-1:0]      al_minutes,
    output logic [NUM_ALARMS-1:0] al_enabled,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  buzzer_out
);

    localparam int PW = $clog2(CLK_HZ);
    localparam int BW =
        (BUZZ_HALF_CYC > 1) ? $clog2(BUZZ_HALF_CYC) : 1;

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_level;
    logic [NUM_BTNS-1:0] btn_press;
    logic                btn_unused;

    assign btn_raw = {al_on_off_toggle_in, al_in,
                      sec_in, min_in, hour_in};

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
        clock_btn_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_btn (
            .clk  (video_clk),
            .rst  (reset),
            .btn  (btn_raw[g]),
            .level(btn_level[g]),
            .press(btn_press[g])
        );
    end

    assign btn_unused = ^{btn_level[BTN_TOG],
                          btn_level[BTN_SEC:BTN_HOUR],
                          btn_press[BTN_AL]};

    logic al_mode;
    logic hour_p;
    logic min_p;
    logic sec_p;
    logic tog_p;

    assign al_mode = btn_level[BTN_AL];
    assign hour_p  = btn_press[BTN_HOUR];
    assign min_p   = btn_press[BTN_MIN];
    assign sec_p   = btn_press[BTN_SEC];
    assign tog_p   = btn_press[BTN_TOG];

    logic [PW-1:0]     presc;
    logic              tick;
    logic              sec_clr;
    alarm_t            alarms [NUM_ALARMS];
    logic [RING_W-1:0] ring_cnt;
    logic [BW-1:0]     buzz_cnt;

    assign tick    = (presc == PW'(CLK_HZ - 1));
    assign sec_clr = sec_p & ~al_mode;

    // Tick-advanced time (used for alarm compare) and final next time
    logic [HOUR_W-1:0] t_hours;
    logic [MIN_W-1:0]  t_mins;
    logic [MIN_W-1:0]  t_secs;
    logic [HOUR_W-1:0] n_hours;
    logic [MIN_W-1:0]  n_mins;
    logic [MIN_W-1:0]  n_secs;

    always_comb begin
        t_hours = hours;
        t_mins  = minutes;
        t_secs  = seconds;
        if (tick) begin
            t_secs = ms_inc(seconds, SECS_MAX);
            if (seconds == MIN_W'(SECS_MAX)) begin
                t_mins = ms_inc(minutes, MINS_MAX);
                if (minutes == MIN_W'(MINS_MAX)) begin
                    t_hours = hour_inc(hours);
                end
            end
        end
        n_hours = t_hours;
        n_mins  = t_mins;
        n_secs  = t_secs;
        if (!al_mode) begin
            if (hour_p) n_hours = hour_inc(t_hours);
            if (min_p)  n_mins  = ms_inc(t_mins, MINS_MAX);
            if (sec_p)  n_secs  = '0;
        end
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            hours    <= '0;
            minutes  <= '0;
            seconds  <= '0;
            sec_tick <= 1'b0;
        end else begin
            hours    <= n_hours;
            minutes  <= n_mins;
            seconds  <= n_secs;
            sec_tick <= tick;
            if (tick || sec_clr) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    logic [NUM_ALARMS-1:0] sel_hit;
    logic [NUM_ALARMS-1:0] trig;
    logic [NUM_ALARMS-1:0] ring_nx;
    logic [RING_W-1:0]     cnt_nx;
    alarm_t                rb;

    always_comb begin
        rb = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel_hit[i] = (al_sel == AW'(i));
            trig[i]    = tick && alarms[i].enable &&
                         (t_secs == '0) &&
                         (t_hours == alarms[i].hours) &&
                         (t_mins == alarms[i].minutes);
            if (sel_hit[i]) rb = alarms[i];
        end
    end

    // A trigger reloads the shared timeout; expiry silences every alarm.
    always_comb begin
        ring_nx = ringing | trig;
        cnt_nx  = ring_cnt;
        if (|trig) begin
            cnt_nx = RING_W'(RING_SEC);
        end else if (tick && (|ringing) && (ring_cnt != '0)) begin
            cnt_nx = ring_cnt - RING_W'(1);
            if (ring_cnt == RING_W'(1)) ring_nx = '0;
        end
        // Toggling an enabled alarm off also dismisses it
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (tog_p && sel_hit[i] && alarms[i].enable) begin
                ring_nx[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alarms[i] <= '0;
            end
            ringing    <= '0;
            ring_cnt   <= '0;
            al_hours   <= '0;
            al_minutes <= '0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                if (sel_hit[i] && al_mode && hour_p) begin
                    alarms[i].hours <= hour_inc(alarms[i].hours);
                end
                if (sel_hit[i] && al_mode && min_p) begin
                    alarms[i].minutes <=
                        ms_inc(alarms[i].minutes, MINS_MAX);
                end
                if (sel_hit[i] && tog_p) begin
                    alarms[i].enable <= ~alarms[i].enable;
                end
            end
            ringing    <= ring_nx;
            ring_cnt   <= cnt_nx;
            al_hours   <= rb.hours;
            al_minutes <= rb.minutes;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            al_enabled[i] = alarms[i].enable;
        end
    end

    // Toggle on count 0 so the first rising edge lands one cycle
    // after ringing appears.
    always_ff @(posedge video_clk or posedge reset) begin
        if (reset) begin
            buzz_cnt   <= '0;
            buzzer_out <= 1'b0;
        end else if (!(|ringing)) begin
            buzz_cnt   <= '0;
            buzzer_out <= 1'b0;
        end else begin
            if (buzz_cnt == '0) buzzer_out <= ~buzzer_out;
            if (buzz_cnt == BW'(BUZZ_HALF_CYC - 1)) begin
                buzz_cnt <= '0;
            end else begin
                buzz_cnt <= buzz_cnt + BW'(1);
            end
        end
    end

endmodule

// File: doc/vga_clock_timekeeper.md
# vga_clock_timekeeper

Parametrised timekeeping and multi-alarm core for the VGA clock design. It counts hours, minutes and seconds from a divided system clock, debounces the five set/alarm buttons, and holds NUM_ALARMS independently enabled alarms. It drives a gated square-wave buzzer and presents binary time and alarm fields to the display renderer.

## Interface
Parameters:
- CLK_HZ, 25_000_000: video_clk cycles per second (≥ 2).
- NUM_ALARMS, 2: number of alarms (1..4).
- DEBOUNCE_CYC, 250_000: consecutive stable cycles required to accept a button level (≥ 1).
- BUZZ_HALF_CYC, 12_500: buzzer half-period in cycles.
- RING_SEC, 60: seconds an alarm rings if not dismissed (1..255).
- Derived: AW = max(1, clog2(NUM_ALARMS)).

Ports:
- video_clk in 1: system clock.
- reset in 1: asynchronous, active-high reset.
- hour_in, min_in, sec_in, al_in, al_on_off_toggle_in in 1 each: raw asynchronous buttons, active high.
- al_sel in AW: selects the alarm targeted by edits, toggles and readback.
- hours out 5: 0..23.
- minutes, seconds out 6 each: 0..59.
- sec_tick out 1: one-cycle pulse when the second advances.
- al_hours out 5, al_minutes out 6: fields of the selected alarm; both 0 if al_sel ≥ NUM_ALARMS.
- al_enabled out NUM_ALARMS: per-alarm enable.
- ringing out NUM_ALARMS: per-alarm ringing flag.
- buzzer_out out 1: square wave while any ringing bit is set, else 0.

## Operation
- Reset values: all outputs and internal state are 0. Time is 00:00:00. Alarms are 00:00 and disabled. The prescaler and buzzer counter are 0.
- Prescaler counts 0..CLK_HZ-1. The wrap cycle is the tick: seconds increment; 59→0 carries into minutes; minute 59→0 carries into hours; hour 23→0.
- Each button passes through a 2-FF synchroniser and then a debouncer. The debounced level changes only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles. A rising edge of the debounced level produces a one-cycle press pulse.
- Presses with al_in debounced low:
  - hour: hours = (hours+1) mod 24.
  - min: minutes = (minutes+1) mod 60, with no carry into hours.
  - sec: seconds = 0 and prescaler = 0.
- Presses with al_in debounced high: hour and min edit the selected alarm using the same mod rules. sec is ignored.
- al_on_off_toggle press: inverts al_enabled[al_sel]. If that alarm becomes disabled, its ringing bit also clears.
- Any edit, toggle or readback with al_sel ≥ NUM_ALARMS is ignored.
- Alarm trigger: on a tick cycle whose post-increment time has seconds = 0 and hh:mm equal to alarm i, and al_enabled[i] = 1, set ringing[i]. Button edits never trigger an alarm.
- Ring timeout: a shared 8-bit counter reloads to RING_SEC on any trigger and decrements on each tick while any ringing bit is set. At 0, all ringing bits clear.
- Dismissal: a toggle press of a ringing alarm clears its ringing bit (and disables it, per the toggle rule).
- Buzzer: while any ringing bit is set, buzzer_out toggles every BUZZ_HALF_CYC cycles. When no bit is set, the output and counter are forced to 0 the next cycle.
- Simultaneous events: the tick is applied first, then the button adjustment to the result. A sec press overrides the tick's seconds value. Alarm compare uses the tick-only result.
- Reset mid-ring or mid-debounce returns every state to reset values immediately (asynchronous). The first tick after release occurs CLK_HZ cycles later.

## Timing
- All outputs are registered. Time fields update on the edge following the tick cycle.
- sec_tick is asserted in the same cycle the new seconds value appears.
- Button-to-effect latency: 2 synchroniser cycles + DEBOUNCE_CYC + 1 pulse cycle + 1 register cycle.
- Ringing asserts together with the triggering time update. The buzzer's first rising edge follows one cycle later.
- Glitches shorter than DEBOUNCE_CYC cycles produce no press.

## Structure
- Shared package vga_clock_pkg holds:
  - HOURS_MAX = 23, MINS_MAX = 59, SECS_MAX = 59.
  - Field widths HOUR_W = 5, MIN_W = 6.
  - An alarm record typedef {enable, hours, minutes}.
- One natural sub-module, clock_btn_debounce: synchroniser, debouncer and edge pulse, parameter DEBOUNCE_CYC, instantiated five times.
- Time, alarm, ring and buzzer logic stay in the top module.

## Test plan
All scenarios use CLK_HZ=10, DEBOUNCE_CYC=4, BUZZ_HALF_CYC=2, RING_SEC=3, NUM_ALARMS=2.
- Reset, then run 10×86400 cycles: time passes 23:59:59 → 00:00:00. sec_tick is pulsed exactly 86400 times.
- Press min_in at 00:59:30 (held 6 cycles): minutes 00, hours still 00. A 3-cycle glitch on hour_in produces no change.
- al_in high, al_sel=1: press hour 7 times, then toggle. Result: al_hours=7, al_enabled=2'b10. Set time to 06:59:59; after 1 tick ringing=2'b10 and buzzer_out toggles every 2 cycles.
- While ringing, press toggle with al_sel=1: ringing=0, al_enabled[1]=0, buzzer_out=0 one cycle after.
- Same alarm left ringing: ringing clears after 3 ticks. Reset asserted mid-ring: all outputs 0 immediately.
- Press sec_in on the tick cycle at 12:00:45: seconds=0, prescaler=0. Next tick arrives exactly 10 cycles later.
